// File: rtl/pitch_tracker.sv
// pitch_tracker
//   Estimates the fundamental period of an offset-binary audio stream. A
//   three-state level detector with hysteresis turns samples into LOW/HIGH
//   levels. Every LOW->HIGH change is a crossing. The number of valid samples
//   between successive crossings is one period. 2^AVG_LOG2 consecutive periods
//   are averaged into period_out.
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   sample_valid  one-cycle strobe qualifying sample
//   sample        unsigned offset-binary sample, BITDEPTH bits
//   period_out    averaged period in sample_valid strobes (registered)
//   period_valid  one-cycle pulse when period_out updates
//   locked        high while a valid averaged period is held
//   timeout       one-cycle pulse when the period counter saturates
module pitch_tracker #(
    parameter int BITDEPTH    = 14,
    parameter int HYST        = 256,
    parameter int PERIOD_BITS = 16,
    parameter int AVG_LOG2    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [BITDEPTH-1:0]    sample,
    output logic [PERIOD_BITS-1:0] period_out,
    output logic                   period_valid,
    output logic                   locked,
    output logic                   timeout
);

    localparam int MID   = (1 << (BITDEPTH - 1)) - 1;
    localparam int ACC_W = PERIOD_BITS + AVG_LOG2;
    // The index needs at least one bit even when no averaging is done.
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [BITDEPTH-1:0]    HI_TH    = BITDEPTH'(MID + HYST);
    localparam logic [BITDEPTH-1:0]    LO_TH    = BITDEPTH'(MID - HYST);
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
    localparam logic [PERIOD_BITS-1:0] CNT_ONE  = PERIOD_BITS'(1);
    localparam logic [PERIOD_BITS-1:0] CNT_MAX  = {PERIOD_BITS{1'b1}};
    localparam logic [PERIOD_BITS-1:0] CNT_NEAR = {{(PERIOD_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_LOW     = 2'd1,
        ST_HIGH    = 2'd2
    } level_t;

    level_t                 state_r;
    logic                   have_ref_r;
    logic [PERIOD_BITS-1:0] count_r;
    logic [ACC_W-1:0]       acc_r;
    logic [IDX_W-1:0]       idx_r;

    logic                   is_high_s;
    logic                   is_low_s;
    logic                   crossing_s;
    logic [ACC_W-1:0]       sum_s;
    logic [PERIOD_BITS-1:0] avg_s;

    // Threshold compare, crossing detect and running sum including the current period.
    always_comb begin
        is_high_s  = 1'b0;
        is_low_s   = 1'b0;
        crossing_s = 1'b0;
        sum_s      = acc_r + ACC_W'(count_r);
        avg_s      = PERIOD_BITS'(sum_s >> AVG_LOG2);
        if (sample >= HI_TH) begin
            is_high_s = 1'b1;
        end else begin
            is_high_s = 1'b0;
        end
        if (sample <= LO_TH) begin
            is_low_s = 1'b1;
        end else begin
            is_low_s = 1'b0;
        end
        if (sample_valid && (state_r == ST_LOW) && is_high_s) begin
            crossing_s = 1'b1;
        end else begin
            crossing_s = 1'b0;
        end
    end

    // Level FSM: UNKNOWN waits for a first low sample so a wave caught mid-high
    // never produces a crossing; samples inside the band keep the current level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_UNKNOWN;
        end else if (sample_valid) begin
            case (state_r)
                ST_UNKNOWN: begin
                    if (is_low_s) begin
                        state_r <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (is_high_s) begin
                        state_r <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (is_low_s) begin
                        state_r <= ST_LOW;
                    end
                end
                default: begin
                    state_r <= ST_UNKNOWN;
                end
            endcase
        end
    end

    // Period counting, averaging, output update and saturation handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_ref_r   <= 1'b0;
            count_r      <= '0;
            acc_r        <= '0;
            idx_r        <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            if (sample_valid) begin
                if (crossing_s) begin
                    // The count before reload is the just-finished period.
                    count_r    <= CNT_ONE;
                    have_ref_r <= 1'b1;
                    if (have_ref_r) begin
                        if (idx_r == IDX_LAST) begin
                            period_out   <= avg_s;
                            period_valid <= 1'b1;
                            locked       <= 1'b1;
                            acc_r        <= '0;
                            idx_r        <= '0;
                        end else begin
                            acc_r <= sum_s;
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end else if (have_ref_r) begin
                    if (count_r == CNT_NEAR) begin
                        // Saturate; clearing have_ref stops further counting,
                        // so timeout fires only once and the next crossing
                        // restarts measurement from scratch.
                        count_r    <= CNT_MAX;
                        timeout    <= 1'b1;
                        have_ref_r <= 1'b0;
                        locked     <= 1'b0;
                        acc_r      <= '0;
                        idx_r      <= '0;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pitch_tracker.sv
module tb_pitch_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [13:0] sample;

    logic [15:0] period_out;
    logic        period_valid, locked, timeout;
    logic [7:0]  p8_out;
    logic        p8_valid, p8_locked, p8_timeout;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    int gap = 1;
    logic last_pv, last_to, last_p8_pv, last_p8_to;

    localparam logic [13:0] LO_V = 14'd0;
    localparam logic [13:0] HI_V = 14'd16383;

    always #5 clk = ~clk;

    pitch_tracker dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .period_out(period_out), .period_valid(period_valid),
        .locked(locked), .timeout(timeout)
    );

    // Short counter, no averaging: covers saturation and per-period output.
    pitch_tracker #(.BITDEPTH(14), .HYST(256), .PERIOD_BITS(8), .AVG_LOG2(0)) dut8 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .period_out(p8_out), .period_valid(p8_valid),
        .locked(p8_locked), .timeout(p8_timeout)
    );

    always @(negedge clk) begin
        if (period_valid) pv_cnt++;
    end

    task automatic send(input logic [13:0] s);
        sample = s;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        last_pv = period_valid;
        last_to = timeout;
        last_p8_pv = p8_valid;
        last_p8_to = p8_timeout;
        sample_valid = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_n(input logic [13:0] s, input int n);
        repeat (n) send(s);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        sample = 14'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (period_out !== 16'd0) begin errors++; $display("FAIL reset_period_out: got %0d expected 0", period_out); end
        checks++; if (period_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got pv=%b lk=%b to=%b expected 0 0 0", period_valid, locked, timeout); end
        checks++; if (p8_out !== 8'd0 || p8_locked !== 1'b0) begin errors++; $display("FAIL reset_p8: got out=%0d lk=%b expected 0 0", p8_out, p8_locked); end
        rst = 1'b0;
    endtask

    task automatic test_basic_lock();
        int pv0;
        gap = 4;
        pv0 = pv_cnt;
        send_n(HI_V, 3);
        send_n(LO_V, 10);
        repeat (4) begin
            send_n(HI_V, 10);
            send_n(LO_V, 10);
        end
        checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL basic_early_pv: got %0d pulses expected 0", pv_cnt - pv0); end
        checks++; if (p8_out !== 8'd20) begin errors++; $display("FAIL basic_p8_period: got %0d expected 20", p8_out); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL basic_prelock: got %b expected 0", locked); end
        send(HI_V);
        checks++; if (last_pv !== 1'b1) begin errors++; $display("FAIL basic_pv_latency: got %b expected 1", last_pv); end
        checks++; if (period_out !== 16'd20) begin errors++; $display("FAIL basic_period: got %0d expected 20", period_out); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked: got %b expected 1", locked); end
        send_n(HI_V, 9);
        send_n(LO_V, 9);
        gap = 1;
    endtask

    task automatic test_averaging();
        int pvs;
        pvs = 0;
        send_n(HI_V, 10); pvs += int'(last_pv);
        send_n(LO_V, 10);
        send_n(HI_V, 11); pvs += int'(last_pv);
        send_n(LO_V, 10);
        send_n(HI_V, 11); pvs += int'(last_pv);
        send_n(LO_V, 11);
        checks++; if (pvs !== 0) begin errors++; $display("FAIL avg_early_pv: got %0d expected 0", pvs); end
        send(HI_V);
        checks++; if (last_pv !== 1'b1 || period_out !== 16'd20) begin errors++; $display("FAIL avg_truncate: got pv=%b out=%0d expected 1 20", last_pv, period_out); end
        checks++; if (last_p8_pv !== 1'b1 || p8_out !== 8'd22) begin errors++; $display("FAIL avg_p8_direct: got pv=%b out=%0d expected 1 22", last_p8_pv, p8_out); end
    endtask

    task automatic test_hold();
        int pv0;
        send_n(HI_V, 9);
        send_n(LO_V, 5);
        pv0 = pv_cnt;
        sample = HI_V;
        sample_valid = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        checks++; if (pv_cnt !== pv0 || period_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL hold_pulses: got pv=%0d expected 0", pv_cnt - pv0); end
        checks++; if (period_out !== 16'd20 || locked !== 1'b1) begin errors++; $display("FAIL hold_outputs: got out=%0d lk=%b expected 20 1", period_out, locked); end
        send_n(LO_V, 5);
        send(HI_V);
        checks++; if (last_p8_pv !== 1'b1 || p8_out !== 8'd20) begin errors++; $display("FAIL hold_period: got pv=%b out=%0d expected 1 20", last_p8_pv, p8_out); end
        send_n(HI_V, 9);
        send_n(LO_V, 10);
        repeat (2) begin
            send_n(HI_V, 10);
            send_n(LO_V, 10);
        end
        send(HI_V);
        checks++; if (last_pv !== 1'b1 || period_out !== 16'd20) begin errors++; $display("FAIL hold_avg: got pv=%b out=%0d expected 1 20", last_pv, period_out); end
    endtask

    task automatic test_band_timeout();
        int to_at, to_seen, pvs, main_to;
        to_at = -1; to_seen = 0; pvs = 0; main_to = 0;
        for (int i = 1; i <= 400; i++) begin
            send(14'(7936 + (i * 37) % 511));
            pvs += int'(last_pv);
            main_to += int'(last_to);
            if (last_p8_to) begin
                to_seen++;
                if (to_at < 0) to_at = i;
            end
        end
        checks++; if (to_at !== 254) begin errors++; $display("FAIL timeout_sample: got %0d expected 254", to_at); end
        checks++; if (to_seen !== 1) begin errors++; $display("FAIL timeout_once: got %0d expected 1", to_seen); end
        checks++; if (p8_locked !== 1'b0 || p8_out !== 8'd20) begin errors++; $display("FAIL timeout_state: got lk=%b out=%0d expected 0 20", p8_locked, p8_out); end
        checks++; if (pvs !== 0 || main_to !== 0 || locked !== 1'b1 || period_out !== 16'd20) begin errors++; $display("FAIL band_main: got pv=%0d to=%0d lk=%b out=%0d expected 0 0 1 20", pvs, main_to, locked, period_out); end
    endtask

    task automatic test_fresh_after_timeout();
        send_n(LO_V, 20);
        send(HI_V);
        checks++; if (last_p8_pv !== 1'b0) begin errors++; $display("FAIL fresh_first: got %b expected 0", last_p8_pv); end
        send_n(HI_V, 9);
        send_n(LO_V, 10);
        send(HI_V);
        checks++; if (last_p8_pv !== 1'b1 || p8_out !== 8'd20 || p8_locked !== 1'b1) begin errors++; $display("FAIL fresh_second: got pv=%b out=%0d lk=%b expected 1 20 1", last_p8_pv, p8_out, p8_locked); end
    endtask

    task automatic test_reset_mid();
        int pv0;
        pulse_rst();
        send_n(LO_V, 15);
        repeat (4) begin
            send_n(HI_V, 15);
            send_n(LO_V, 15);
        end
        pulse_rst();
        checks++; if (period_out !== 16'd0 || locked !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got out=%0d lk=%b expected 0 0", period_out, locked); end
        send_n(LO_V, 10);
        pv0 = pv_cnt;
        repeat (4) begin
            send_n(HI_V, 10);
            send_n(LO_V, 10);
        end
        checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL rstmid_early_pv: got %0d expected 0", pv_cnt - pv0); end
        send(HI_V);
        checks++; if (last_pv !== 1'b1 || period_out !== 16'd20) begin errors++; $display("FAIL rstmid_period: got pv=%b out=%0d expected 1 20", last_pv, period_out); end
    endtask

    task automatic test_min_period();
        int pv0;
        pulse_rst();
        pv0 = pv_cnt;
        repeat (4) begin
            send(14'd7935);
            send(14'd8447);
        end
        checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL minp_early_pv: got %0d expected 0", pv_cnt - pv0); end
        checks++; if (p8_out !== 8'd2) begin errors++; $display("FAIL minp_p8: got %0d expected 2", p8_out); end
        send(14'd7935);
        send(14'd8447);
        checks++; if (last_pv !== 1'b1 || period_out !== 16'd2 || locked !== 1'b1) begin errors++; $display("FAIL minp_period: got pv=%b out=%0d lk=%b expected 1 2 1", last_pv, period_out, locked); end
    endtask

    initial begin
        last_pv = 1'b0; last_to = 1'b0; last_p8_pv = 1'b0; last_p8_to = 1'b0;
        test_reset();
        test_basic_lock();
        test_averaging();
        test_hold();
        test_band_timeout();
        test_fresh_after_timeout();
        test_reset_mid();
        test_min_period();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
